dds_tone_capture: RTL

// Downstream companion of the DDS phase-sweep sequencer. It watches the DDS phase-config handshake to detect each new

---
 rtl/dds_tone_capture_if.sv | 21 ++
 rtl/dds_tone_capture.sv | 132 +++++++++++++
 2 files changed

// File: rtl/dds_tone_capture_if.sv
// Bundles the monitored DDS config/data streams and the result AXI-Stream for dds_tone_capture.
interface dds_tone_capture_if;
  logic        cfg_tvalid;
  logic        cfg_tready;
  logic [31:0] cfg_tdata;
  logic        dds_tvalid;
  logic [31:0] dds_tdata;
  logic        m_axis_res_tvalid;
  logic        m_axis_res_tready;
  logic [63:0] m_axis_res_tdata;

  modport master (
    output cfg_tvalid, cfg_tready, cfg_tdata, dds_tvalid, dds_tdata, m_axis_res_tready,
    input  m_axis_res_tvalid, m_axis_res_tdata
  );

  modport slave (
    input  cfg_tvalid, cfg_tready, cfg_tdata, dds_tvalid, dds_tdata, m_axis_res_tready,
    output m_axis_res_tvalid, m_axis_res_tdata
  );
endinterface

// File: rtl/dds_tone_capture.sv
// Per-step tone capture: detects a new DDS phase step, skips settling samples, then reports
// peak |sin| / |cos| over a fixed window as one 64-bit record.
module dds_tone_capture #(
  parameter int DATA_W = 16,
  parameter int SETTLE = 8,
  parameter int WINDOW = 64,
  parameter int CNT_W  = 16
) (
  input  logic                clk,
  input  logic                rst,
  dds_tone_capture_if.slave   io,
  output logic                overflow,
  output logic                aborted,
  output logic [1:0]          state
);
  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_SETTLE  = 2'd1;
  localparam logic [1:0] S_MEASURE = 2'd2;
  localparam logic [1:0] S_EMIT    = 2'd3;

  localparam logic [1:0]       S_FIRST     = (SETTLE == 0) ? S_MEASURE : S_SETTLE;
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'((SETTLE == 0) ? 0 : SETTLE - 1);
  localparam logic [CNT_W-1:0] WINDOW_LAST = CNT_W'(WINDOW - 1);

  logic [1:0]        r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_pk_sin, r_pk_cos;
  logic [31:0]       r_phase, r_last_phase, r_pend_phase;
  logic              r_last_valid, r_pend_valid;
  logic              r_tvalid;
  logic [63:0]       r_tdata;
  logic              r_overflow, r_aborted;

  logic [DATA_W-1:0] w_sin_abs, w_cos_abs, w_pk_sin_nxt, w_pk_cos_nxt;
  logic              w_ev, w_hs, w_start;
  logic [31:0]       w_start_phase;

  function automatic logic [DATA_W-1:0] f_abs(input logic [DATA_W-1:0] x);
    if (!x[DATA_W-1])
      return x;
    if (x == {1'b1, {(DATA_W-1){1'b0}}})
      return {1'b0, {(DATA_W-1){1'b1}}};
    return -x;
  endfunction

  always_comb begin
    w_sin_abs    = f_abs(io.dds_tdata[16 +: DATA_W]);
    w_cos_abs    = f_abs(io.dds_tdata[0 +: DATA_W]);
    w_pk_sin_nxt = (w_sin_abs > r_pk_sin) ? w_sin_abs : r_pk_sin;
    w_pk_cos_nxt = (w_cos_abs > r_pk_cos) ? w_cos_abs : r_pk_cos;
    w_ev = io.cfg_tvalid & io.cfg_tready & (~r_last_valid | (io.cfg_tdata != r_last_phase));
    w_hs = r_tvalid & io.m_axis_res_tready;
    // A fresh step begins from IDLE, on abort, or when a result drains with a step waiting.
    w_start = 1'b0;
    case (r_state)
      S_IDLE, S_SETTLE, S_MEASURE: w_start = w_ev;
      S_EMIT:                      w_start = w_hs & (w_ev | r_pend_valid);
      default:                     w_start = 1'b0;
    endcase
    w_start_phase = w_ev ? io.cfg_tdata : r_pend_phase;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_pk_sin     <= '0;
      r_pk_cos     <= '0;
      r_phase      <= '0;
      r_last_phase <= '0;
      r_last_valid <= 1'b0;
      r_pend_phase <= '0;
      r_pend_valid <= 1'b0;
      r_tvalid     <= 1'b0;
      r_tdata      <= '0;
      r_overflow   <= 1'b0;
      r_aborted    <= 1'b0;
    end else begin
      if (w_ev) begin
        r_last_phase <= io.cfg_tdata;
        r_last_valid <= 1'b1;
      end
      if (w_ev && (r_state == S_SETTLE || r_state == S_MEASURE))
        r_aborted <= 1'b1;
      if (r_state == S_EMIT) begin
        if (w_hs) begin
          r_tvalid     <= 1'b0;
          r_pend_valid <= 1'b0;
          if (!w_start)
            r_state <= S_IDLE;
        end else if (w_ev) begin
          if (r_pend_valid)
            r_overflow <= 1'b1;
          r_pend_phase <= io.cfg_tdata;
          r_pend_valid <= 1'b1;
        end
      end
      if (w_start) begin
        r_phase  <= w_start_phase;
        r_cnt    <= '0;
        r_pk_sin <= '0;
        r_pk_cos <= '0;
        r_state  <= S_FIRST;
      end else if (io.dds_tvalid) begin
        if (r_state == S_SETTLE) begin
          if (r_cnt == SETTLE_LAST) begin
            r_cnt   <= '0;
            r_state <= S_MEASURE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end else if (r_state == S_MEASURE) begin
          r_pk_sin <= w_pk_sin_nxt;
          r_pk_cos <= w_pk_cos_nxt;
          if (r_cnt == WINDOW_LAST) begin
            r_tdata  <= {r_phase, 16'(w_pk_sin_nxt), 16'(w_pk_cos_nxt)};
            r_tvalid <= 1'b1;
            r_state  <= S_EMIT;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
      end
    end
  end

  assign io.m_axis_res_tvalid = r_tvalid;
  assign io.m_axis_res_tdata  = r_tdata;
  assign overflow             = r_overflow;
  assign aborted              = r_aborted;
  assign state                = r_state;
endmodule
